vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_if.sv | 49 ++++
 rtl/clk_en_div.sv | 53 +++++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 640x480@60 default timing constants and a line/frame total
//             helper shared by the VGA timing generator files.
//  Revision : 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;
  localparam int c_pix_div  = 4;

  function automatic int calc_total(input int active, input int fp,
                                    input int sync_w, input int bp);
    return active + fp + sync_w + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_if
//  Purpose  : Run enable plus timing outputs of vga_timing_gen. The frameCount
//             member exists only when VGA_TIMING_FRAME_CNT_EN is defined.
//  Revision : 1.0
// ============================================================================
interface vga_timing_if #(
  parameter int HW = $clog2(vga_timing_pkg::calc_total(vga_timing_pkg::c_h_active,
                            vga_timing_pkg::c_h_fp, vga_timing_pkg::c_h_sync,
                            vga_timing_pkg::c_h_bp)),
  parameter int VW = $clog2(vga_timing_pkg::calc_total(vga_timing_pkg::c_v_active,
                            vga_timing_pkg::c_v_fp, vga_timing_pkg::c_v_sync,
                            vga_timing_pkg::c_v_bp))
) ();

  logic          en;
  logic          hSync;
  logic          vSync;
  logic          bright;
  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;
  logic          pixStrobe;
  logic          lineStart;
  logic          frameStart;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frameCount;
`endif

  modport master (
    input  en,
    output hSync, vSync, bright, hCount, vCount,
    output pixStrobe, lineStart, frameStart
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frameCount
`endif
  );

  modport slave (
    output en,
    input  hSync, vSync, bright, hCount, vCount,
    input  pixStrobe, lineStart, frameStart
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frameCount
`endif
  );

endinterface
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
//  Module   : clk_en_div
//  Purpose  : Registered clock-enable divider; tick pulses for one cycle each
//             time the 0..DIV-1 count wraps while en is high.
//  Revision : 1.0
// ============================================================================
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  logic r_tick;

  generate
    if (DIV <= 1) begin : g_div1
      always_ff @(posedge ClkPort) begin
        if (Reset) r_tick <= 1'b0;
        else       r_tick <= en;
      end
    end else begin : g_divn
      localparam int              c_cw   = $clog2(DIV);
      localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

      logic [c_cw-1:0] r_cnt;

      always_ff @(posedge ClkPort) begin
        if (Reset) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else if (en) begin
          if (r_cnt == c_last) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end
      end
    end
  endgenerate

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parameterised VGA raster timing: pixel strobe, h/v counters,
//             registered syncs and active-area flag. Defining
//             VGA_TIMING_FRAME_CNT_EN adds a 16-bit completed-frame counter.
//  Revision : 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = c_h_active,
  parameter int   H_FP     = c_h_fp,
  parameter int   H_SYNC   = c_h_sync,
  parameter int   H_BP     = c_h_bp,
  parameter int   V_ACTIVE = c_v_active,
  parameter int   V_FP     = c_v_fp,
  parameter int   V_SYNC   = c_v_sync,
  parameter int   V_BP     = c_v_bp,
  parameter int   PIX_DIV  = c_pix_div,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic         ClkPort,
  input  logic         Reset,
  vga_timing_if.master vif
);

  localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
  localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
  localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
  localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_first   = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_last    = c_hw'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [c_vw-1:0] c_vs_first   = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_last    = c_vw'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic            w_tick;
  logic            w_adv;
  logic [c_hw-1:0] w_h_next;
  logic [c_vw-1:0] w_v_next;
  logic [c_hw-1:0] r_h;
  logic [c_vw-1:0] r_v;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_bright;

  clk_en_div #(.DIV(PIX_DIV)) u_div (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .en      (vif.en),
    .tick    (w_tick)
  );

  // The strobe shows the pixel currently held; counts step on the edge that
  // follows it, provided en is still high there.
  assign w_adv = vif.en & w_tick;

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_adv) begin
      if (r_h == c_h_last) begin
        w_h_next = '0;
        w_v_next = (r_v == c_v_last) ? '0 : r_v + 1'b1;
      end else begin
        w_h_next = r_h + 1'b1;
      end
    end
  end

  // Syncs and bright are decoded from the next counts so they land on the
  // same edge as the counts they describe.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_h      <= '0;
      r_v      <= '0;
      r_hsync  <= ~HS_POL;
      r_vsync  <= ~VS_POL;
      r_bright <= 1'b1;
    end else begin
      r_h      <= w_h_next;
      r_v      <= w_v_next;
      r_hsync  <= ((w_h_next >= c_hs_first) && (w_h_next <= c_hs_last)) ? HS_POL : ~HS_POL;
      r_vsync  <= ((w_v_next >= c_vs_first) && (w_v_next <= c_vs_last)) ? VS_POL : ~VS_POL;
      r_bright <= (w_h_next < c_h_act) && (w_v_next < c_v_act);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge ClkPort) begin
    if (Reset)
      r_frame_cnt <= '0;
    else if (w_adv && (r_h == c_h_last) && (r_v == c_v_last))
      r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign vif.frameCount = r_frame_cnt;
`endif

  assign vif.hSync      = r_hsync;
  assign vif.vSync      = r_vsync;
  assign vif.bright     = r_bright;
  assign vif.hCount     = r_h;
  assign vif.vCount     = r_v;
  assign vif.pixStrobe  = w_tick;
  assign vif.lineStart  = w_tick & (r_h == '0);
  assign vif.frameStart = w_tick & (r_h == '0) & (r_v == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench: small 14x7 configuration driven from a
//             vector table plus pause/reset/frame-count sequences, and the
//             640x480 default configuration observed over two lines.
//  Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.HW(4),  .VW(3))  vif_s ();
  vga_timing_if #(.HW(10), .VW(10)) vif_b ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .ClkPort (clk),
    .Reset   (rst_s),
    .vif     (vif_s.master)
  );

  vga_timing_gen u_big (
    .ClkPort (clk),
    .Reset   (rst_b),
    .vif     (vif_b.master)
  );

  typedef struct {
    int n;
    int h;
    int v;
    int hs;
    int vs;
    int br;
    int st;
    int ls;
    int fs;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_until_s(input int h, input int v, input int lim, input string name);
    int k;
    k = 0;
    while (!((int'(vif_s.hCount) == h) && (int'(vif_s.vCount) == v)) && (k < lim)) begin
      tick();
      k++;
    end
    check(name, int'((int'(vif_s.hCount) == h) && (int'(vif_s.vCount) == v)), 1);
  endtask

  initial begin
    int cyc;
    int k;
    int first_edge, last_edge, fs_first, gap_err;
    int n_strobe, n_line, n_frame, n_hs_low, n_vs_low, n_bright;
    int hs_min, hs_max, max_br, max_h, fs_wo_ls, stray, h;

    //       n    h  v  hs vs br st ls fs
    vecs[0]  = '{0,   0, 0, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{1,   0, 0, 0, 0, 1, 1, 1, 1};
    vecs[2]  = '{2,   1, 0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{8,   7, 0, 0, 0, 1, 1, 0, 0};
    vecs[4]  = '{9,   8, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{11, 10, 0, 1, 0, 0, 1, 0, 0};
    vecs[6]  = '{12, 11, 0, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{13, 12, 0, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{14, 13, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{15,  0, 1, 0, 0, 1, 1, 1, 0};
    vecs[10] = '{57,  0, 4, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{71,  0, 5, 0, 1, 0, 1, 1, 0};
    vecs[12] = '{85,  0, 6, 0, 0, 0, 1, 1, 0};
    vecs[13] = '{98, 13, 6, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{99,  0, 0, 0, 0, 1, 1, 1, 1};
    vecs[15] = '{109, 10, 0, 1, 0, 0, 1, 0, 0};

    rst_s    = 1'b1;
    rst_b    = 1'b1;
    vif_s.en = 1'b1;
    vif_b.en = 1'b1;
    repeat (3) tick();
    rst_s = 1'b0;

    // Small configuration: n = clock edges since reset release.
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      while (cyc < vecs[i].n) begin
        tick();
        cyc++;
      end
      check($sformatf("vec%0d.hCount", i),     int'(vif_s.hCount),     vecs[i].h);
      check($sformatf("vec%0d.vCount", i),     int'(vif_s.vCount),     vecs[i].v);
      check($sformatf("vec%0d.hSync", i),      int'(vif_s.hSync),      vecs[i].hs);
      check($sformatf("vec%0d.vSync", i),      int'(vif_s.vSync),      vecs[i].vs);
      check($sformatf("vec%0d.bright", i),     int'(vif_s.bright),     vecs[i].br);
      check($sformatf("vec%0d.pixStrobe", i),  int'(vif_s.pixStrobe),  vecs[i].st);
      check($sformatf("vec%0d.lineStart", i),  int'(vif_s.lineStart),  vecs[i].ls);
      check($sformatf("vec%0d.frameStart", i), int'(vif_s.frameStart), vecs[i].fs);
    end

    // Pause with en low at hCount=5 of line 1.
    run_until_s(5, 1, 200, "pause.reach");
    vif_s.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("pause%0d.hCount", i),    int'(vif_s.hCount),    5);
      check($sformatf("pause%0d.vCount", i),    int'(vif_s.vCount),    1);
      check($sformatf("pause%0d.pixStrobe", i), int'(vif_s.pixStrobe), 0);
      check($sformatf("pause%0d.lineStart", i), int'(vif_s.lineStart), 0);
      check($sformatf("pause%0d.bright", i),    int'(vif_s.bright),    1);
    end
    vif_s.en = 1'b1;
    k = 0;
    while ((int'(vif_s.hCount) == 5) && (k < 4)) begin
      tick();
      k++;
    end
    check("resume.hCount", int'(vif_s.hCount), 6);
    check("resume.vCount", int'(vif_s.vCount), 1);

    // Reset in the middle of a frame.
    run_until_s(9, 3, 300, "midreset.reach");
    check("midreset.bright_before", int'(vif_s.bright), 0);
    rst_s = 1'b1;
    tick();
    check("midreset.hCount",    int'(vif_s.hCount),    0);
    check("midreset.vCount",    int'(vif_s.vCount),    0);
    check("midreset.bright",    int'(vif_s.bright),    1);
    check("midreset.hSync",     int'(vif_s.hSync),     0);
    check("midreset.vSync",     int'(vif_s.vSync),     0);
    check("midreset.pixStrobe", int'(vif_s.pixStrobe), 0);
    rst_s = 1'b0;
    tick();
    check("release.pixStrobe",  int'(vif_s.pixStrobe),  1);
    check("release.frameStart", int'(vif_s.frameStart), 1);
    check("release.lineStart",  int'(vif_s.lineStart),  1);
    check("release.hCount",     int'(vif_s.hCount),     0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    rst_s = 1'b1;
    tick();
    check("fcnt.reset", int'(vif_s.frameCount), 0);
    rst_s = 1'b0;
    repeat (294) tick();
    check("fcnt.before3", int'(vif_s.frameCount), 2);
    tick();
    check("fcnt.after3", int'(vif_s.frameCount), 3);
`endif

    // Default 640x480 configuration, two full lines.
    tick();
    rst_b = 1'b0;
    check("big.rst.hCount",     int'(vif_b.hCount),     0);
    check("big.rst.vCount",     int'(vif_b.vCount),     0);
    check("big.rst.hSync",      int'(vif_b.hSync),      1);
    check("big.rst.vSync",      int'(vif_b.vSync),      1);
    check("big.rst.bright",     int'(vif_b.bright),     1);
    check("big.rst.pixStrobe",  int'(vif_b.pixStrobe),  0);
    check("big.rst.frameStart", int'(vif_b.frameStart), 0);

    first_edge = 0; last_edge = 0; fs_first = 0; gap_err = 0;
    n_strobe = 0; n_line = 0; n_frame = 0; n_hs_low = 0; n_vs_low = 0;
    n_bright = 0; hs_min = 9999; hs_max = -1; max_br = -1; max_h = -1;
    fs_wo_ls = 0; stray = 0;
    for (int e = 1; e <= 6400; e++) begin
      tick();
      h = int'(vif_b.hCount);
      if (vif_b.pixStrobe) begin
        n_strobe++;
        if (first_edge == 0) begin
          first_edge = e;
          fs_first   = int'(vif_b.frameStart);
        end else if (e - last_edge != 4) begin
          gap_err++;
        end
        last_edge = e;
        if (vif_b.lineStart)  n_line++;
        if (vif_b.frameStart) n_frame++;
        if (!vif_b.hSync) begin
          n_hs_low++;
          if (h < hs_min) hs_min = h;
          if (h > hs_max) hs_max = h;
        end
        if (!vif_b.vSync) n_vs_low++;
        if (vif_b.bright) begin
          n_bright++;
          if (h > max_br) max_br = h;
        end
        if (h > max_h) max_h = h;
      end else if (vif_b.lineStart || vif_b.frameStart) begin
        stray++;
      end
      if (vif_b.frameStart && !vif_b.lineStart) fs_wo_ls++;
    end
    check("big.first_strobe_edge", first_edge, 4);
    check("big.first_frameStart",  fs_first,   1);
    check("big.strobe_gap_err",    gap_err,    0);
    check("big.strobes",           n_strobe,   1600);
    check("big.lineStarts",        n_line,     2);
    check("big.frameStarts",       n_frame,    1);
    check("big.hsync_low_pixels",  n_hs_low,   192);
    check("big.hsync_low_first",   hs_min,     656);
    check("big.hsync_low_last",    hs_max,     751);
    check("big.vsync_low_pixels",  n_vs_low,   0);
    check("big.bright_pixels",     n_bright,   1280);
    check("big.bright_last",       max_br,     639);
    check("big.max_hCount",        max_h,      799);
    check("big.fs_without_ls",     fs_wo_ls,   0);
    check("big.stray_pulses",      stray,      0);
    check("big.final_hCount",      int'(vif_b.hCount), 799);
    check("big.final_vCount",      int'(vif_b.vCount), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
